// File: rtl/matrix_scan_capture.sv
// Captures an 8x8 bicolour multiplexed row scan into a readable frame buffer.
// Build option: SCAN_ORDER_CHECK_EN adds the sticky order_err output.
module matrix_scan_capture #(
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = 64
) (
    input  logic       clk_1kHz,
    input  logic       rst,
    input  logic [7:0] row,
    input  logic [7:0] col_r,
    input  logic [7:0] col_g,
    input  logic       err_clr,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_r,
    output logic [7:0] rd_g,
    output logic       frame_valid,
    output logic [7:0] frame_cnt,
    output logic       scan_active,
    output logic       scan_err,
`ifdef SCAN_ORDER_CHECK_EN
    output logic       order_err,
`endif
    output logic [2:0] cur_row
);

    localparam logic [3:0] SETTLE_W  = 4'(SETTLE);
    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    logic [7:0] r_row_q;
    logic [7:0] r_row_prev;
    logic [7:0] r_cr_q;
    logic [7:0] r_cg_q;
    logic [3:0] r_stab;
    logic [7:0] r_idle;
    logic [7:0] r_seen;
    logic [7:0] r_buf_r [8];
    logic [7:0] r_buf_g [8];
    logic [7:0] r_rd_r;
    logic [7:0] r_rd_g;
    logic       r_fv;
    logic [7:0] r_fcnt;
    logic       r_active;
    logic       r_err;
    logic [2:0] r_cur;

    logic       w_changed;
    logic [3:0] w_stab_nxt;
    logic       w_settle_hit;
    logic       w_onehot;
    logic       w_blank;
    logic [2:0] w_idx;
    logic       w_acc_row;
    logic       w_acc_bad;
    logic [7:0] w_idle_nxt;
    logic       w_timeout;
    logic       w_frame_done;
    logic [7:0] w_seen_base;
    logic [7:0] w_seen_nxt;

    assign w_changed  = (r_row_q != r_row_prev);
    assign w_stab_nxt = w_changed ? 4'd1 :
                        (r_stab == 4'd15) ? 4'd15 : r_stab + 4'd1;

    // A saturated counter sitting at SETTLE must not re-accept the dwell
    assign w_settle_hit = (w_stab_nxt == SETTLE_W) &&
                          (w_changed || (r_stab != SETTLE_W));

    always_comb begin
        w_onehot = 1'b0;
        w_idx    = 3'd0;
        w_blank  = (r_row_q == 8'hFF);
        case (r_row_q)
            8'hFE: begin w_onehot = 1'b1; w_idx = 3'd0; end
            8'hFD: begin w_onehot = 1'b1; w_idx = 3'd1; end
            8'hFB: begin w_onehot = 1'b1; w_idx = 3'd2; end
            8'hF7: begin w_onehot = 1'b1; w_idx = 3'd3; end
            8'hEF: begin w_onehot = 1'b1; w_idx = 3'd4; end
            8'hDF: begin w_onehot = 1'b1; w_idx = 3'd5; end
            8'hBF: begin w_onehot = 1'b1; w_idx = 3'd6; end
            8'h7F: begin w_onehot = 1'b1; w_idx = 3'd7; end
            default: ;
        endcase
    end

    assign w_acc_row = w_settle_hit && w_onehot;
    assign w_acc_bad = w_settle_hit && !w_onehot && !w_blank;

    assign w_idle_nxt = w_acc_row ? 8'd0 :
                        (r_idle == 8'hFF) ? 8'hFF : r_idle + 8'd1;
    assign w_timeout  = !w_acc_row && (w_idle_nxt == TIMEOUT_W);

    assign w_frame_done = (r_seen == 8'hFF);

    // Completion and timeout both restart the mask; a row landing now still counts
    always_comb begin
        w_seen_base = r_seen;
        if (w_frame_done || w_timeout) begin
            w_seen_base = 8'd0;
        end
        w_seen_nxt = w_seen_base;
        if (w_acc_row) begin
            w_seen_nxt = w_seen_base | (8'd1 << w_idx);
        end
    end

    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            r_row_q    <= 8'hFF;
            r_row_prev <= 8'hFF;
            r_cr_q     <= 8'd0;
            r_cg_q     <= 8'd0;
            r_stab     <= 4'd0;
            r_idle     <= 8'd0;
        end else begin
            r_row_q    <= row;
            r_row_prev <= r_row_q;
            r_cr_q     <= col_r;
            r_cg_q     <= col_g;
            r_stab     <= w_stab_nxt;
            r_idle     <= w_idle_nxt;
        end
    end

    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                r_buf_r[k] <= 8'd0;
                r_buf_g[k] <= 8'd0;
            end
            r_rd_r <= 8'd0;
            r_rd_g <= 8'd0;
        end else begin
            if (w_acc_row) begin
                r_buf_r[w_idx] <= r_cr_q;
                r_buf_g[w_idx] <= r_cg_q;
            end
            r_rd_r <= r_buf_r[rd_row];
            r_rd_g <= r_buf_g[rd_row];
        end
    end

    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            r_seen   <= 8'd0;
            r_fv     <= 1'b0;
            r_fcnt   <= 8'd0;
            r_active <= 1'b0;
            r_err    <= 1'b0;
            r_cur    <= 3'd0;
        end else begin
            r_seen <= w_seen_nxt;
            r_fv   <= w_frame_done;
            if (w_frame_done) begin
                r_fcnt <= r_fcnt + 8'd1;
            end
            if (w_acc_row) begin
                r_active <= 1'b1;
                r_cur    <= w_idx;
            end else if (w_timeout) begin
                r_active <= 1'b0;
            end
            if (w_acc_bad) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

`ifdef SCAN_ORDER_CHECK_EN
    logic [2:0] r_last_idx;
    logic       r_armed;
    logic       r_order_err;
    logic       w_order_bad;

    // First row after reset or timeout has no predecessor to compare against
    assign w_order_bad = w_acc_row && r_armed &&
                         (w_idx != (r_last_idx + 3'd1));

    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            r_last_idx  <= 3'd0;
            r_armed     <= 1'b0;
            r_order_err <= 1'b0;
        end else begin
            if (w_acc_row) begin
                r_last_idx <= w_idx;
                r_armed    <= 1'b1;
            end else if (w_timeout) begin
                r_armed    <= 1'b0;
            end
            if (w_order_bad) begin
                r_order_err <= 1'b1;
            end else if (err_clr) begin
                r_order_err <= 1'b0;
            end
        end
    end

    assign order_err = r_order_err;
`endif

    assign rd_r        = r_rd_r;
    assign rd_g        = r_rd_g;
    assign frame_valid = r_fv;
    assign frame_cnt   = r_fcnt;
    assign scan_active = r_active;
    assign scan_err    = r_err;
    assign cur_row     = r_cur;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Directed bench for matrix_scan_capture: SETTLE=1 and SETTLE=2 instances
// share one stimulus bus; order checks run when SCAN_ORDER_CHECK_EN is set.
module tb_matrix_scan_capture;

    logic       clk;
    logic       rst;
    logic [7:0] row;
    logic [7:0] col_r;
    logic [7:0] col_g;
    logic       err_clr;
    logic [2:0] rd_row;

    logic [7:0] rd_r1, rd_g1, fcnt1;
    logic       fv1, act1, err1;
    logic [2:0] cur1;
    logic [7:0] rd_r2, rd_g2, fcnt2;
    logic       fv2, act2, err2;
    logic [2:0] cur2;
`ifdef SCAN_ORDER_CHECK_EN
    logic       oerr1, oerr2;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fv_pulses = 0;
    int fv_last   = 0;

    matrix_scan_capture #(.SETTLE(1), .TIMEOUT(64)) u_dut1 (
        .clk_1kHz(clk), .rst(rst), .row(row), .col_r(col_r),
        .col_g(col_g), .err_clr(err_clr), .rd_row(rd_row),
        .rd_r(rd_r1), .rd_g(rd_g1), .frame_valid(fv1),
        .frame_cnt(fcnt1), .scan_active(act1), .scan_err(err1),
`ifdef SCAN_ORDER_CHECK_EN
        .order_err(oerr1),
`endif
        .cur_row(cur1)
    );

    matrix_scan_capture #(.SETTLE(2), .TIMEOUT(64)) u_dut2 (
        .clk_1kHz(clk), .rst(rst), .row(row), .col_r(col_r),
        .col_g(col_g), .err_clr(err_clr), .rd_row(rd_row),
        .rd_r(rd_r2), .rd_g(rd_g2), .frame_valid(fv2),
        .frame_cnt(fcnt2), .scan_active(act2), .scan_err(err2),
`ifdef SCAN_ORDER_CHECK_EN
        .order_err(oerr2),
`endif
        .cur_row(cur2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fv1) begin
            fv_pulses++;
            fv_last = cyc;
        end
    end

    typedef struct {
        logic [2:0] rd;
        logic [7:0] er;
        logic [7:0] eg;
    } rb_vec_t;

    rb_vec_t rb_tab [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        row     = 8'hFF;
        col_r   = 8'h00;
        col_g   = 8'h00;
        err_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        fv_pulses = 0;
    endtask

    task automatic put_row(input int i, input logic [7:0] r,
                           input logic [7:0] g);
        logic [7:0] one;
        one   = 8'd1 << i;
        row   = ~one;
        col_r = r;
        col_g = g;
        tick();
    endtask

    task automatic send_frame();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 8'(8'h11 * i);
            put_row(i, v, ~v);
        end
        row = 8'hFF;
    endtask

    task automatic blank(input int n);
        row = 8'hFF;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int c0;
        int first_off;
        logic act_k2;
        logic err_any;

        rb_tab[0] = '{3'd0, 8'h00, 8'hFF};
        rb_tab[1] = '{3'd1, 8'h11, 8'hEE};
        rb_tab[2] = '{3'd2, 8'h22, 8'hDD};
        rb_tab[3] = '{3'd3, 8'h33, 8'hCC};
        rb_tab[4] = '{3'd4, 8'h44, 8'hBB};
        rb_tab[5] = '{3'd5, 8'h55, 8'hAA};
        rb_tab[6] = '{3'd6, 8'h66, 8'h99};
        rb_tab[7] = '{3'd7, 8'h77, 8'h88};

        rst = 1'b1;
        row = 8'($urandom);
        col_r = 8'($urandom);
        col_g = 8'($urandom);
        err_clr = 1'b1;
        rd_row = 3'd0;
        tick();
        row = 8'($urandom);
        tick();
        chk("rst_fv", {31'd0, fv1}, 0);
        chk("rst_cnt", {24'd0, fcnt1}, 0);
        chk("rst_act", {31'd0, act1}, 0);
        chk("rst_err", {31'd0, err1}, 0);
        chk("rst_cur", {29'd0, cur1}, 0);
        chk("rst_rd", {16'd0, rd_r1, rd_g1}, 0);
        row = 8'hFF;
        err_clr = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_row = 3'(i);
            tick();
            chk("rst_buf", {16'd0, rd_r1, rd_g1}, 0);
        end

        do_reset();
        c0 = cyc;
        send_frame();
        blank(6);
        chk("ff_pulses", fv_pulses, 1);
        chk("ff_latency", fv_last - c0, 10);
        chk("ff_cnt", {24'd0, fcnt1}, 1);
        chk("ff_err", {31'd0, err1}, 0);
        chk("ff_cur", {29'd0, cur1}, 7);
        chk("ff_act", {31'd0, act1}, 1);
        for (int i = 0; i < 8; i++) begin
            rd_row = rb_tab[i].rd;
            tick();
            chk("ff_rd_r", {24'd0, rd_r1}, {24'd0, rb_tab[i].er});
            chk("ff_rd_g", {24'd0, rd_g1}, {24'd0, rb_tab[i].eg});
        end

        row = 8'h00;
        tick(); tick(); tick();
        chk("inv_set", {31'd0, err1}, 1);
        blank(5);
        chk("inv_sticky", {31'd0, err1}, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("inv_clr", {31'd0, err1}, 0);
        row = 8'h00;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        row = 8'hFF;
        chk("inv_set_wins", {31'd0, err1}, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("inv_clr2", {31'd0, err1}, 0);

        first_off = 0;
        act_k2 = 1'b0;
        err_any = 1'b0;
        put_row(2, 8'h5A, 8'hA5);
        row = 8'hFF;
        for (int k = 2; k <= 100; k++) begin
            tick();
            if (k == 2) act_k2 = act1;
            if (!act1 && first_off == 0) first_off = k;
            err_any = err_any | err1;
        end
        chk("to_act_on", {31'd0, act_k2}, 1);
        chk("to_act_drop", first_off, 66);
        chk("to_no_err", {31'd0, err_any}, 0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            put_row(i, 8'(8'h11 * i), 8'(~(8'h11 * i)));
        end
        blank(64);
        for (int i = 5; i < 8; i++) begin
            put_row(i, 8'(8'h11 * i), 8'(~(8'h11 * i)));
        end
        blank(5);
        chk("part_no_fv", fv_pulses, 0);
        chk("part_cnt", {24'd0, fcnt1}, 0);
        rd_row = 3'd3;
        tick();
        chk("part_kept", {24'd0, rd_r1}, 32'h33);
        send_frame();
        blank(4);
        chk("part_full", fv_pulses, 1);
        chk("part_full_cnt", {24'd0, fcnt1}, 1);

        do_reset();
        put_row(3, 8'h3C, 8'hC3);
        put_row(4, 8'h4D, 8'hB2);
        put_row(4, 8'h4D, 8'hB2);
        for (int k = 0; k < 5; k++) put_row(4, 8'hEE, 8'hEE);
        blank(3);
        chk("gl_cur", {29'd0, cur2}, 4);
        rd_row = 3'd3;
        tick();
        chk("gl_row3", {16'd0, rd_r2, rd_g2}, 0);
        chk("gl_s1_row3", {24'd0, rd_r1}, 32'h3C);
        rd_row = 3'd4;
        tick();
        chk("gl_row4", {16'd0, rd_r2, rd_g2}, 32'h4DB2);
        chk("gl_s1_row4", {16'd0, rd_r1, rd_g1}, 32'h4DB2);

`ifdef SCAN_ORDER_CHECK_EN
        do_reset();
        put_row(0, 8'h01, 8'h01);
        put_row(1, 8'h02, 8'h02);
        chk("ord_ok", {31'd0, oerr1}, 0);
        put_row(3, 8'h03, 8'h03);
        blank(3);
        chk("ord_set", {31'd0, oerr1}, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ord_clr", {31'd0, oerr1}, 0);
        blank(70);
        put_row(7, 8'h07, 8'h07);
        put_row(0, 8'h08, 8'h08);
        blank(3);
        chk("ord_wrap", {31'd0, oerr1}, 0);
        chk("ord_cur", {29'd0, cur1}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
